sync_general_driver: RTL and testbench

// Initiator side of the Start/Din -> Ready/Dout/Error handshake used by sync_general.

---
 rtl/sync_general_driver.sv | 137 +++++++++++++
 tb/tb_sync_general_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_general_driver.sv
// Initiator for the Start/Din -> Ready/Dout/Error handshake: sweeps operands Lo..Hi (wrapping),
// captures each result, counts errors and aborts through a watchdog if the responder stalls.
module sync_general_driver #(
    parameter int unsigned DATA_BITS      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 63,
    parameter int unsigned TW             = 6
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Go,
    input  logic [DATA_BITS-1:0] Lo,
    input  logic [DATA_BITS-1:0] Hi,
    output logic                 Start,
    output logic [DATA_BITS-1:0] Din,
    input  logic                 Ready,
    input  logic                 Error,
    input  logic [DATA_BITS-1:0] Dout,
    output logic                 Res_valid,
    output logic [DATA_BITS-1:0] Res_op,
    output logic [DATA_BITS-1:0] Res_data,
    output logic                 Res_err,
    output logic [DATA_BITS-1:0] Err_count,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    localparam logic [TW-1:0]        WD_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]        WD_ONE   = TW'(1);
    localparam logic [DATA_BITS-1:0] D_ONE    = DATA_BITS'(1);
    localparam logic [DATA_BITS-1:0] ALL_ONES = '1;

    logic [1:0]           state_q, state_d;
    logic [DATA_BITS-1:0] hi_q, hi_d;
    logic [TW-1:0]        wd_q, wd_d;
    logic [DATA_BITS-1:0] din_d, res_op_d, res_data_d, err_count_d;
    logic                 res_valid_d, res_err_d, timeout_d;

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        wd_d        = wd_q;
        din_d       = Din;
        res_valid_d = 1'b0;
        res_op_d    = Res_op;
        res_data_d  = Res_data;
        res_err_d   = Res_err;
        err_count_d = Err_count;
        timeout_d   = Timeout;
        case (state_q)
            IDLE: begin
                if (Go) begin
                    hi_d        = Hi;
                    din_d       = Lo;
                    err_count_d = '0;
                    timeout_d   = 1'b0;
                    wd_d        = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (Ready) begin
                    res_valid_d = 1'b1;
                    res_op_d    = Din;
                    res_data_d  = Dout;
                    res_err_d   = Error;
                    if (Error && (Err_count != ALL_ONES)) err_count_d = Err_count + D_ONE;
                    wd_d        = '0;
                    state_d     = GAP;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            GAP: begin
                // Wait for the responder to return Ready to zero before the next operand.
                if (!Ready) begin
                    wd_d = '0;
                    if (Din == hi_q) begin
                        state_d = FIN;
                    end else begin
                        din_d   = Din + D_ONE;
                        state_d = ISSUE;
                    end
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            wd_q      <= '0;
            Din       <= '0;
            Start     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Res_valid <= 1'b0;
            Res_op    <= '0;
            Res_data  <= '0;
            Res_err   <= 1'b0;
            Err_count <= '0;
            Timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            wd_q      <= wd_d;
            Din       <= din_d;
            Start     <= (state_d == ISSUE);
            Busy      <= (state_d == ISSUE) || (state_d == GAP);
            Done      <= (state_d == FIN);
            Res_valid <= res_valid_d;
            Res_op    <= res_op_d;
            Res_data  <= res_data_d;
            Res_err   <= res_err_d;
            Err_count <= err_count_d;
            Timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sync_general_driver.sv
// Directed bench for sync_general_driver with a behavioural responder and a result monitor.
module tb_sync_general_driver;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Go;
    logic [5:0] Lo, Hi;
    logic       Start;
    logic [5:0] Din;
    logic       Ready = 1'b0;
    logic       Error = 1'b0;
    logic [5:0] Dout = '0;
    logic       Res_valid;
    logic [5:0] Res_op, Res_data;
    logic       Res_err;
    logic [5:0] Err_count;
    logic       Busy, Done, Timeout;

    int n_assert = 0;
    int n_fail   = 0;

    sync_general_driver #(
        .DATA_BITS      (6),
        .TIMEOUT_CYCLES (63),
        .TW             (6)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Go        (Go),
        .Lo        (Lo),
        .Hi        (Hi),
        .Start     (Start),
        .Din       (Din),
        .Ready     (Ready),
        .Error     (Error),
        .Dout      (Dout),
        .Res_valid (Res_valid),
        .Res_op    (Res_op),
        .Res_data  (Res_data),
        .Res_err   (Res_err),
        .Err_count (Err_count),
        .Busy      (Busy),
        .Done      (Done),
        .Timeout   (Timeout)
    );

    always #5 Clk = ~Clk;

    // Responder: mode 0 answers 2 cycles after Start, 1 never answers, 2 never drops Ready.
    int       mode   = 0;
    int       rcnt   = 0;
    logic     err_en = 1'b0;
    logic [5:0] err_op = '0;

    always @(negedge Clk) begin
        if (!Start) begin
            rcnt = 0;
            if (!(mode == 2 && Ready)) Ready = 1'b0;
        end else begin
            rcnt = rcnt + 1;
            if (mode != 1 && rcnt >= 2) begin
                Ready = 1'b1;
                Dout  = Din + 6'd1;
                Error = err_en && (Din == err_op);
            end
        end
    end

    logic [5:0] mon_op   [0:15];
    logic [5:0] mon_data [0:15];
    logic       mon_err  [0:15];
    int res_n = 0, done_cnt = 0, gap_cnt = 0, start_hi_cnt = 0;

    always @(posedge Clk) begin
        #1;
        if (Res_valid) begin
            if (res_n < 16) begin
                mon_op[res_n]   = Res_op;
                mon_data[res_n] = Res_data;
                mon_err[res_n]  = Res_err;
            end
            res_n = res_n + 1;
        end
        if (Done) done_cnt = done_cnt + 1;
        if (Busy && !Start) gap_cnt = gap_cnt + 1;
        if (Start) start_hi_cnt = start_hi_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        res_n        = 0;
        done_cnt     = 0;
        gap_cnt      = 0;
        start_hi_cnt = 0;
    endtask

    task automatic start_sweep(input logic [5:0] lo, input logic [5:0] hi);
        @(negedge Clk);
        Lo = lo;
        Hi = hi;
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    logic [5:0] exp_op2 [0:3];
    logic [5:0] exp_dat2[0:3];

    initial begin
        Rst_n = 1'b0;
        Go    = 1'b0;
        Lo    = '0;
        Hi    = '0;
        #3;
        check("rst_start",     32'(Start),     32'd0);
        check("rst_busy",      32'(Busy),      32'd0);
        check("rst_done",      32'(Done),      32'd0);
        check("rst_timeout",   32'(Timeout),   32'd0);
        check("rst_err_count", 32'(Err_count), 32'd0);
        check("rst_res_valid", 32'(Res_valid), 32'd0);
        check("rst_din",       32'(Din),       32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Basic sweep 0..3
        clear_mon();
        start_sweep(6'd0, 6'd3);
        wait_done(200);
        repeat (2) @(negedge Clk);
        check("t1_count", 32'(res_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_op",   32'(mon_op[i]),   32'(i));
            check("t1_data", 32'(mon_data[i]), 32'(i + 1));
            check("t1_err",  32'(mon_err[i]),  32'd0);
        end
        check("t1_err_count", 32'(Err_count), 32'd0);
        check("t1_done_cnt",  32'(done_cnt),  32'd1);
        check("t1_timeout",   32'(Timeout),   32'd0);
        check("t1_din_hold",  32'(Din),       32'd3);
        check("t1_busy",      32'(Busy),      32'd0);

        // Wrapping sweep 62..1
        exp_op2  = '{6'd62, 6'd63, 6'd0, 6'd1};
        exp_dat2 = '{6'd63, 6'd0, 6'd1, 6'd2};
        clear_mon();
        start_sweep(6'd62, 6'd1);
        wait_done(200);
        repeat (2) @(negedge Clk);
        check("t2_count", 32'(res_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_op",   32'(mon_op[i]),   32'(exp_op2[i]));
            check("t2_data", 32'(mon_data[i]), 32'(exp_dat2[i]));
        end
        check("t2_gap_cycles", 32'(gap_cnt >= 3), 32'd1);
        check("t2_done_cnt",   32'(done_cnt),     32'd1);

        // Error on operand 5 only
        err_en = 1'b1;
        err_op = 6'd5;
        clear_mon();
        start_sweep(6'd0, 6'd7);
        wait_done(300);
        repeat (2) @(negedge Clk);
        err_en = 1'b0;
        check("t3_count", 32'(res_n), 32'd8);
        for (int i = 0; i < 8; i++) check("t3_res_err", 32'(mon_err[i]), 32'(i == 5));
        check("t3_err_count", 32'(Err_count), 32'd1);

        // Responder never answers: watchdog in ISSUE
        mode = 1;
        clear_mon();
        start_sweep(6'd10, 6'd20);
        wait_done(200);
        repeat (2) @(negedge Clk);
        check("t4_start_high", 32'(start_hi_cnt), 32'd63);
        check("t4_timeout",    32'(Timeout),      32'd1);
        check("t4_start",      32'(Start),        32'd0);
        check("t4_count",      32'(res_n),        32'd0);
        check("t4_done_cnt",   32'(done_cnt),     32'd1);
        check("t4_err_cleared", 32'(Err_count),   32'd0);

        // Ready stuck high: watchdog in GAP
        mode = 2;
        clear_mon();
        start_sweep(6'd5, 6'd9);
        wait_done(300);
        repeat (2) @(negedge Clk);
        check("t4b_count",   32'(res_n),     32'd1);
        check("t4b_op",      32'(mon_op[0]), 32'd5);
        check("t4b_gap",     32'(gap_cnt),   32'd63);
        check("t4b_timeout", 32'(Timeout),   32'd1);
        check("t4b_done",    32'(done_cnt),  32'd1);
        mode = 0;
        repeat (2) @(negedge Clk);

        // Reset mid-ISSUE
        clear_mon();
        start_sweep(6'd0, 6'd3);
        check("t5_timeout_cleared", 32'(Timeout), 32'd0);
        check("t5_start_on",        32'(Start),   32'd1);
        check("t5_busy_on",         32'(Busy),    32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("t5_rst_start",     32'(Start),     32'd0);
        check("t5_rst_busy",      32'(Busy),      32'd0);
        check("t5_rst_res_valid", 32'(Res_valid), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("t5_no_done",   32'(done_cnt), 32'd0);
        check("t5_idle_busy", 32'(Busy),     32'd0);
        clear_mon();
        start_sweep(6'd2, 6'd3);
        wait_done(200);
        repeat (2) @(negedge Clk);
        check("t5_count", 32'(res_n),     32'd2);
        check("t5_op0",   32'(mon_op[0]), 32'd2);
        check("t5_op1",   32'(mon_op[1]), 32'd3);

        // Go while busy and in FIN is ignored
        clear_mon();
        start_sweep(6'd0, 6'd3);
        repeat (3) @(negedge Clk);
        Lo = 6'd40;
        Hi = 6'd50;
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        wait_done(200);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        check("t6_fin_go_busy",  32'(Busy),  32'd0);
        check("t6_fin_go_start", 32'(Start), 32'd0);
        repeat (2) @(negedge Clk);
        check("t6_count", 32'(res_n), 32'd4);
        for (int i = 0; i < 4; i++) check("t6_op", 32'(mon_op[i]), 32'(i));
        check("t6_done_cnt", 32'(done_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
